// File: rtl/prog_delay_line_pkg.sv
// Shared types, limits and helpers for the programmable delay line.
package prog_delay_line_pkg;

  localparam int DW_MAX        = 32;
  localparam int MAX_DEPTH_MAX = 16;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Map a requested depth into the legal range 1..max_depth.
  function automatic int unsigned clamp_depth(input int unsigned sel,
                                              input int unsigned max_depth);
    if (sel == 0) return 1;
    if (sel > max_depth) return max_depth;
    return sel;
  endfunction

endpackage

// File: rtl/prog_delay_stage.sv
// One delay-line register stage: data, valid and (with PROG_DELAY_LINE_PARITY_EN) a parity bit.
// clear_i drops the valid bit only; load_i captures the upstream stage.
module prog_delay_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
`ifdef PROG_DELAY_LINE_PARITY_EN
  input  logic          par_i,
  output logic          par_o,
`endif
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
`ifdef PROG_DELAY_LINE_PARITY_EN
  logic          par_q, par_d;
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
`ifdef PROG_DELAY_LINE_PARITY_EN
    par_d   = par_q;
`endif
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
`ifdef PROG_DELAY_LINE_PARITY_EN
      par_d   = par_i;
`endif
    end
  end

  // NOTE: reset is sampled on the clock edge and every register uses <= so all stages update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef PROG_DELAY_LINE_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef PROG_DELAY_LINE_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
`ifdef PROG_DELAY_LINE_PARITY_EN
  assign par_o   = par_q;
`endif

endmodule

// File: rtl/prog_delay_line.sv
// Programmable shift-register delay line with drain-before-depth-change, stall, flush and occupancy.
// Optional stage parity and parity_err output are enabled by PROG_DELAY_LINE_PARITY_EN.
module prog_delay_line
  import prog_delay_line_pkg::*;
#(
  parameter  int DW        = 8,
  parameter  int MAX_DEPTH = 8,
  parameter  int DEPTH_RST = 2,
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [DEPTH_W-1:0] depth_sel,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [DEPTH_W-1:0] cur_depth,
  output logic [DEPTH_W-1:0] occupancy
`ifdef PROG_DELAY_LINE_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  if (DW < 1 || DW > DW_MAX) begin : g_bad_dw
    $error("prog_delay_line: DW out of range");
  end
  if (MAX_DEPTH < 2 || MAX_DEPTH > MAX_DEPTH_MAX) begin : g_bad_depth
    $error("prog_delay_line: MAX_DEPTH out of range");
  end
  if (DEPTH_RST < 1 || DEPTH_RST > MAX_DEPTH) begin : g_bad_rst
    $error("prog_delay_line: DEPTH_RST out of range");
  end

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] cur_depth_q, cur_depth_d;
  logic [DEPTH_W-1:0] occ_q, occ_d;

  logic               st_valid [MAX_DEPTH];
  logic [DW-1:0]      st_data  [MAX_DEPTH];
`ifdef PROG_DELAY_LINE_PARITY_EN
  logic               st_par   [MAX_DEPTH];
  logic               out_par;
`endif

  logic [DEPTH_W-1:0] depth_clamped;
  logic [DEPTH_W-1:0] out_idx;
  logic               depth_match;
  logic               accept;
  logic               shift;

  assign depth_clamped = DEPTH_W'(clamp_depth(32'(depth_sel), MAX_DEPTH));
  assign depth_match   = (depth_clamped == cur_depth_q);
  assign in_ready      = rst_n && (state_q == RUN) && !flush && depth_match;
  assign accept        = in_valid & in_ready & en;
  assign shift         = en & ~flush;
  assign out_idx       = cur_depth_q - DEPTH_W'(1);

  for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
    logic          v_in;
    logic [DW-1:0] d_in;
`ifdef PROG_DELAY_LINE_PARITY_EN
    logic          p_in;
`endif
    if (i == 0) begin : g_head
      assign v_in = accept;
      assign d_in = in_data;
`ifdef PROG_DELAY_LINE_PARITY_EN
      assign p_in = ^in_data;
`endif
    end else begin : g_tail
      // Words leaving the active window lose their valid bit, so a later depth
      // increase can never resurrect them as duplicates.
      assign v_in = st_valid[i-1] & (DEPTH_W'(i) < cur_depth_q);
      assign d_in = st_data[i-1];
`ifdef PROG_DELAY_LINE_PARITY_EN
      assign p_in = st_par[i-1];
`endif
    end

    prog_delay_stage #(.DW(DW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (shift),
      .clear_i (flush),
      .valid_i (v_in),
      .data_i  (d_in),
`ifdef PROG_DELAY_LINE_PARITY_EN
      .par_i   (p_in),
      .par_o   (st_par[i]),
`endif
      .valid_o (st_valid[i]),
      .data_o  (st_data[i])
    );
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
`ifdef PROG_DELAY_LINE_PARITY_EN
    out_par   = 1'b0;
`endif
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (DEPTH_W'(i) == out_idx) begin
        out_valid = st_valid[i];
        out_data  = st_data[i];
`ifdef PROG_DELAY_LINE_PARITY_EN
        out_par   = st_par[i];
`endif
      end
    end
  end

  always_comb begin
    occ_d       = occ_q;
    state_d     = state_q;
    cur_depth_d = cur_depth_q;
    if (flush) begin
      occ_d       = '0;
      state_d     = RUN;
      cur_depth_d = depth_clamped;
    end else begin
      if (en) begin
        if (accept && !out_valid)      occ_d = occ_q + DEPTH_W'(1);
        else if (!accept && out_valid) occ_d = occ_q - DEPTH_W'(1);
      end
      case (state_q)
        RUN: begin
          if (!depth_match) begin
            if (occ_q != '0) state_d     = DRAIN;
            else             cur_depth_d = depth_clamped;
          end
        end
        DRAIN: begin
          if (occ_q == '0) begin
            state_d     = RUN;
            cur_depth_d = depth_clamped;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cur_depth_q <= DEPTH_W'(DEPTH_RST);
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_depth_q <= cur_depth_d;
      occ_q       <= occ_d;
    end
  end

  assign cur_depth = cur_depth_q;
  assign occupancy = occ_q;
`ifdef PROG_DELAY_LINE_PARITY_EN
  assign parity_err = out_valid & ((^out_data) != out_par);
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: directed scenarios followed by randomized traffic.
// Expected words carry the enabled-edge count at which they must appear at the output.
module tb_prog_delay_line;

  localparam int DW        = 8;
  localparam int MAX_DEPTH = 8;
  localparam int DEPTH_RST = 2;
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst_n, en, flush, in_valid, in_ready, out_valid;
  logic [DW-1:0]      in_data, out_data;
  logic [DEPTH_W-1:0] depth_sel, cur_depth, occupancy;
`ifdef PROG_DELAY_LINE_PARITY_EN
  logic               parity_err;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } word_t;

  word_t exp_q[$];
  int    en_cnt  = 0;
  int    m_depth = DEPTH_RST;
  bit    m_drain = 1'b0;
  bit    mon_on  = 1'b0;
  int    checks  = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  prog_delay_line #(
    .DW(DW), .MAX_DEPTH(MAX_DEPTH), .DEPTH_RST(DEPTH_RST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .depth_sel (depth_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .cur_depth (cur_depth),
    .occupancy (occupancy)
`ifdef PROG_DELAY_LINE_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampm(input int s);
    if (s == 0) return 1;
    if (s > MAX_DEPTH) return MAX_DEPTH;
    return s;
  endfunction

  function automatic bit m_out_valid();
    return exp_q.size() > 0 && exp_q[0].due == en_cnt;
  endfunction

  // Monitor: compares the presented output against the scoreboard head.
  always @(negedge clk) begin
    if (mon_on) begin
      check("out_valid", 32'(out_valid), 32'(m_out_valid()));
      if (out_valid && m_out_valid())
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
      check("occupancy", 32'(occupancy), 32'(exp_q.size()));
      check("cur_depth", 32'(cur_depth), 32'(m_depth));
      check("in_ready", 32'(in_ready),
            32'(rst_n && !m_drain && !flush && clampm(int'(depth_sel)) == m_depth));
`ifdef PROG_DELAY_LINE_PARITY_EN
      check("parity_err", 32'(parity_err), 32'd0);
`endif
    end
  end

  // Apply one cycle of stimulus and advance the reference model over the edge.
  task automatic cycle(input bit r, input bit e, input bit f, input bit v,
                       input logic [DW-1:0] d, input int ds);
    bit    acc;
    int    occ;
    word_t w;
    rst_n = r; en = e; flush = f; in_valid = v; in_data = d; depth_sel = DEPTH_W'(ds);
    acc = r && e && v && !f && !m_drain && clampm(ds) == m_depth;
    @(posedge clk);
    #1;
    occ = exp_q.size();
    if (!r) begin
      exp_q.delete();
      m_depth = DEPTH_RST;
      m_drain = 1'b0;
    end else if (f) begin
      exp_q.delete();
      m_depth = clampm(ds);
      m_drain = 1'b0;
    end else begin
      if (e) begin
        if (exp_q.size() > 0 && exp_q[0].due == en_cnt) void'(exp_q.pop_front());
        en_cnt++;
        if (acc) begin
          w.data = d;
          w.due  = en_cnt + m_depth - 1;
          exp_q.push_back(w);
        end
      end
      if (!m_drain && clampm(ds) != m_depth) begin
        if (occ != 0) m_drain = 1'b1;
        else          m_depth = clampm(ds);
      end else if (m_drain && occ == 0) begin
        m_drain = 1'b0;
        m_depth = clampm(ds);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] seq [4];
    int            ds;
    bit            r, e, f, v;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 2);
    check("reset_cur_depth", 32'(cur_depth), 32'(DEPTH_RST));
    check("reset_occupancy", 32'(occupancy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    mon_on = 1'b1;

    foreach (seq[i]) cycle(1'b1, 1'b1, 1'b0, 1'b1, seq[i], 2);
    check("occ_settled", 32'(occupancy), 32'd2);

    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 2);
    check("stall_occ", 32'(occupancy), 32'd2);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 2);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 2);

    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 5);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h78, 5);
    check("drain_cur_depth", 32'(cur_depth), 32'd5);
    check("drain_in_ready_back", 32'(in_ready), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 5);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5);

    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, DW'(i), 5);
    check("pre_flush_occ", 32'(occupancy), 32'd3);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hEE, 7);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_cur_depth", 32'(cur_depth), 32'd7);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 7);
    check("flush_no_accept", 32'(occupancy), 32'd0);

    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    check("clamp_low", 32'(cur_depth), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 15);
    check("clamp_high", 32'(cur_depth), 32'(MAX_DEPTH));

`ifdef PROG_DELAY_LINE_PARITY_EN
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b1, DW'($urandom), 2);
    check("parity_setup", 32'(out_valid), 32'd1);
    force dut.out_data = out_data ^ DW'(1);
    #1;
    check("parity_forced", 32'(parity_err), 32'd1);
    release dut.out_data;
    #1;
    check("parity_clean", 32'(parity_err), 32'd0);
`endif

    ds = 3;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 499) != 0);
      e = ($urandom_range(0, 4) != 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) ds = int'($urandom_range(0, 15));
      cycle(r, e, f, v, DW'($urandom), ds);
    end
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, ds);
    check("final_drained", 32'(occupancy), 32'd0);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
